pc_ctrl: RTL
============

# pc_ctrl

Fetch-stage program-counter controller for the 5-stage MIPS core. It sits directly downstream of the decode-stage branch comparator and consumes its taken/not-taken result, together with decode-resolved jump targets and the exception redirect. It owns the PC register and honours the MIPS one-instruction branch delay slot. It also holds a redirect pending across fetch stalls, so that a branch resolved while fetch is frozen is not lost.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stallF  in  1  fetch stall (imem wait or hazard); PC holds.
- stallD  in  1  decode stall; branch/jump inputs are ignored while high.
- branchD  in  1  decode instruction is a conditional branch (beq/bne/bgtz/blez/bltz/bgez/bltzal/bgezal).
- branch_takenD  in  1  comparator result for the decode instruction.
- branch_targetD  in  32  decode PC+4 + (sign-extended offset << 2).
- jumpD  in  1  decode instruction is j/jal/jr/jalr.
- jump_targetD  in  32  resolved jump target; register operand is already forwarded.
- flush_exc  in  1  exception or eret redirect from the commit point.
- exc_pc  in  32  exception vector or EPC.
- pcF  out  32  current fetch address.
- pc_plus4F  out  32  pcF + 4.
- is_in_delayslotF  out  1  the instruction at pcF is a delay-slot instruction.
- pc_adelF  out  1  pcF[1:0] != 2'b00 (fetch address error).
- redirect_pending  out  1  high in state PENDING.

## Operation
- accept = !stallD & ((branchD & branch_takenD) | jumpD). The target is jump_targetD if jumpD is set, else branch_targetD. branchD and jumpD are never both high. If both are high, jumpD wins.
- A not-taken branch with !stallD is still a branch, so the instruction at pcF is a delay slot. Define ctl = !stallD & (branchD | jumpD).
- State machine IDLE / PENDING, with a 32-bit pend_target register.
- IDLE:
  - accept & !stallF: pcF <= target. Stay in IDLE.
  - accept & stallF: pend_target <= target, go to PENDING. pcF holds.
  - !accept & !stallF: pcF <= pcF + 4.
  - !accept & stallF: hold.
- PENDING:
  - stallF: hold. New accept pulses are ignored, because decode cannot advance past the delay slot.
  - !stallF: pcF <= pend_target, go to IDLE.
- flush_exc has priority over everything except rst. pcF <= exc_pc regardless of stallF, state goes to IDLE, and pend_target is discarded.
- Priority order: rst > flush_exc > PENDING release > accept > sequential increment.
- is_in_delayslotF (combinational) = !rst & !flush_exc & (ctl | state==PENDING). It stays high for every cycle pcF is held at the delay slot.
- Arithmetic: pcF + 4 is mod 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000. Targets are not realigned; misalignment is reported only through pc_adelF.

## Timing
- Reset values:
  - pcF = RESET_PC
  - pc_plus4F = RESET_PC+4
  - state IDLE
  - pend_target = 0
  - redirect_pending = 0
  - is_in_delayslotF = 0 during rst
  - pc_adelF = 0 (RESET_PC aligned)
- Redirect latency:
  - accept in cycle N with stallF=0 → pcF = target in cycle N+1.
  - stallF high in N..N+k → pcF = target in N+k+2, the cycle after the first stallF=0 cycle.
- flush_exc in cycle N → pcF = exc_pc in N+1, even with stallF=1 or state PENDING.
- rst asserted mid-PENDING → next cycle IDLE with pcF = RESET_PC. The pending target is dropped.
- pc_plus4F and pc_adelF are combinational from the pcF register. There is no comb path from stallF to pcF.

## Test plan
- Reset then 3 free-running cycles → pcF sequence BFC00000, BFC00004, BFC00008, BFC0000C; is_in_delayslotF = 0 throughout.
- pcF=BFC00010, branchD=1, branch_takenD=1, target BFC00100, stallF=0 → is_in_delayslotF=1 that cycle; next cycle pcF=BFC00100.
- Same branch with stallF=1 for 3 cycles → pcF held at BFC00010 with redirect_pending=1 and is_in_delayslotF=1; the cycle after stallF falls, pcF=BFC00100.
- Not-taken branch at pcF=BFC00020 → is_in_delayslotF=1 for one cycle; pcF=BFC00024.
- In PENDING, assert flush_exc with exc_pc=BFC00380 → next pcF=BFC00380, redirect_pending=0, and the pending target is never fetched.
- jr with jump_targetD=0000_0002 → pcF=00000002 and pc_adelF=1. Separately, pcF=FFFFFFFC with no redirect → next pcF=00000000.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program counter with branch delay slot handling,
// redirect hold across fetch stalls, and exception redirect.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        branchD,
  input  logic        branch_takenD,
  input  logic [31:0] branch_targetD,
  input  logic        jumpD,
  input  logic [31:0] jump_targetD,
  input  logic        flush_exc,
  input  logic [31:0] exc_pc,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic        is_in_delayslotF,
  output logic        pc_adelF,
  output logic        redirect_pending
);

  localparam int unsigned AW = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] pend_target;

  logic          accept;
  logic          ctl;
  logic [AW-1:0] target;

  // Decode-side redirect request; a jump overrides a branch if both are raised
  always_comb begin
    accept = 1'b0;
    ctl    = 1'b0;
    target = branch_targetD;
    if (jumpD) begin
      target = jump_targetD;
    end
    if (!stallD) begin
      accept = (branchD & branch_takenD) | jumpD;
      ctl    = branchD | jumpD;
    end
  end

  // PC register and redirect-hold state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF         <= RESET_PC;
      state       <= IDLE;
      pend_target <= '0;
    end else if (flush_exc) begin
      pcF         <= exc_pc;
      state       <= IDLE;
      pend_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (stallF) begin
              pend_target <= target;
              state       <= PENDING;
            end else begin
              pcF <= target;
            end
          end else if (!stallF) begin
            pcF <= pcF + AW'(4);
          end
        end
        PENDING: begin
          // Decode is frozen behind the delay slot, so new requests are ignored here
          if (!stallF) begin
            pcF   <= pend_target;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs derived from the PC register and current decode request
  always_comb begin
    pc_plus4F        = pcF + AW'(4);
    pc_adelF         = |pcF[1:0];
    redirect_pending = (state == PENDING);
    is_in_delayslotF = !rst & !flush_exc & (ctl | (state == PENDING));
  end

endmodule
